rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback stage (WB) and a multi-cycle unit (MC, e.g. multiply/divide or a long-latency load).
- MC results are buffered in a small in-order queue and drained when WB leaves the port idle.
- Tracks queued destination registers so decode can detect RAW hazards.
- Forces the port to WB-free cycles when MC is starved.
- Sits between the WB stage/MC unit and the register file write inputs.

Parameters:
DEPTH, 2, MC queue entries (power of two, 2..8)
STARVE_LIMIT, 4, consecutive cycles a non-empty queue may be denied before the pipeline is stalled

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wb_we  in  1  WB write request
wb_rw  in  5  WB destination register
wb_di  in  32  WB write data
wb_memtoreg  in  2  WB result select; 2'b10 = JAL (destination forced to $31)
mc_valid  in  1  MC result valid
mc_ready  out  1  queue can accept (registered: !full)
mc_rw  in  5  MC destination register
mc_di  in  32  MC result
id_ra  in  5  decode source A
id_rb  in  5  decode source B
id_hazard  out  1  source A or B matches a queued destination
wb_stall  out  1  pipeline must hold WB this cycle
Wr_RegWr  out  1  register-file write enable
Wr_Rw  out  5  register-file write address (already JAL-resolved)
Wr_RegDi  out  32  register-file write data

Behaviour:
- Reset (rst low, async): queue empty, starve counter 0.
- While rst is low: Wr_RegWr=0, mc_ready=0, id_hazard=0, wb_stall=0, Wr_Rw=0, Wr_RegDi=0.
- WB effective destination: 31 if wb_memtoreg==2'b10, else wb_rw. A WB request with effective destination 0 is a no-op; it does not occupy the port.
- Grant (combinational, per cycle):
  - wb_stall=1 → queue head.
  - else live WB request → WB.
  - else queue non-empty → head.
  - else none.
  - Wr_RegWr=1 only when granted; Wr_Rw/Wr_RegDi are taken from the grantee, and are 0 when no grant.
- Queue:
  - FIFO, in order.
  - Enqueue on mc_valid && mc_ready at the clock edge.
  - mc_rw==0 is accepted and discarded (never enqueued).
  - Dequeue when head is granted.
  - mc_ready = count<DEPTH, registered from count; no enqueue when full even if a dequeue happens the same cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous enqueue+dequeue keeps count.
- Latency: an accepted MC result is written no earlier than the cycle after acceptance (bypass off).
- WAW squash: if WB writes register r while a queued entry targets r, that entry is invalidated (dropped at dequeue without asserting Wr_RegWr). The WB value persists.
- id_hazard: combinational. High if a nonzero id_ra or id_rb equals the destination of any valid queued entry.
- Starvation:
  - counter increments each cycle the queue is non-empty and WB holds the port; clears on any head dequeue or when the queue is empty.
  - When counter==STARVE_LIMIT, wb_stall=1 for exactly one cycle; head is written and the counter clears.
  - The WB stage must hold its request; the arbiter ignores wb_* while wb_stall=1.
- Reset mid-operation discards all queued entries; no partial write.

Optional Feature:
RF_BYPASS_EN:
- Defined: when the queue is empty, WB is not requesting and mc_valid is high with mc_rw≠0, the MC result is written the same cycle (Wr_* driven from mc_*) and not enqueued. mc_ready is unchanged in timing.
- Undefined: every MC result is enqueued first; minimum latency 1 cycle.

Test Plan:
- Reset: rst low mid-run with 2 entries queued → Wr_RegWr=0, mc_ready=0; after release mc_ready=1, count 0, no write of old entries.
- JAL/zero: wb_we=1, wb_memtoreg=2'b10, wb_rw=5, wb_di=0x1234 → Wr_Rw=31, Wr_RegDi=0x1234. wb_rw=0 (non-JAL) → Wr_RegWr=0.
- Queue fill: WB busy; MC pushes r8=0xA, r9=0xB → mc_ready falls after 2nd accept; id_ra=9 → id_hazard=1. WB idles → writes r8 then r9 on successive cycles, mc_ready=1 after first drain.
- Starvation: queue holds r4=0x55, WB requests every cycle → wb_stall=1 on cycle STARVE_LIMIT+1 after enqueue, Wr_Rw=4, Wr_RegDi=0x55.
- WAW squash: queued r7=0x1, WB writes r7=0x2 → queued entry dropped; r7 final value 0x2; no second write to r7.
- Bypass (RF_BYPASS_EN): queue empty, WB idle, mc r3=0x77 → Wr_RegWr=1, Wr_Rw=3 the same cycle; without the macro the write occurs the next cycle.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the pipeline-side signals around the register-file write arbiter.
// The slave modport is the arbiter. The master modport is the WB stage, the MC unit,
// decode and the register file taken together.
interface rf_write_arbiter_if;
  logic        wb_we;
  logic [4:0]  wb_rw;
  logic [31:0] wb_di;
  logic [1:0]  wb_memtoreg;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rw;
  logic [31:0] mc_di;
  logic [4:0]  id_ra;
  logic [4:0]  id_rb;
  logic        id_hazard;
  logic        wb_stall;
  logic        Wr_RegWr;
  logic [4:0]  Wr_Rw;
  logic [31:0] Wr_RegDi;

  modport slave (
    input  wb_we, wb_rw, wb_di, wb_memtoreg, mc_valid, mc_rw, mc_di, id_ra, id_rb,
    output mc_ready, id_hazard, wb_stall, Wr_RegWr, Wr_Rw, Wr_RegDi
  );

  modport master (
    output wb_we, wb_rw, wb_di, wb_memtoreg, mc_valid, mc_rw, mc_di, id_ra, id_rb,
    input  mc_ready, id_hazard, wb_stall, Wr_RegWr, Wr_Rw, Wr_RegDi
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter. The in-order WB stage and a multi-cycle unit (MC)
// share one write port.
// - MC results wait in an in-order queue and drain on cycles where WB leaves the port idle.
// - A WB write squashes any queued entry that targets the same register.
// - A starvation counter forces one WB-free cycle when the queue head has waited too long.
// Optional: define RF_BYPASS_EN so that an MC result is written in the same cycle
// whenever the queue is empty and WB is idle.
module rf_write_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  rf_write_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_HEAD, GNT_BYP} grant_e;

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic             mc_ready_q;
  logic [DEPTH-1:0] q_vld_q, q_vld_d;
  logic [4:0]       q_rw_q [DEPTH];
  logic [31:0]      q_di_q [DEPTH];

  logic [4:0]  wb_eff_rw;
  logic        wb_live, q_empty, stall, bypass, enq, deq;
  grant_e      grant;
  logic        wr_we;
  logic [4:0]  wr_rw;
  logic [31:0] wr_di;
  logic        hazard;

  assign wb_eff_rw = (bus.wb_memtoreg == 2'b10) ? 5'd31 : bus.wb_rw;
  assign wb_live   = bus.wb_we && (wb_eff_rw != 5'd0);
  assign q_empty   = (count_q == '0);
  assign stall     = !q_empty && (starve_q == STV_W'(STARVE_LIMIT));

`ifdef RF_BYPASS_EN
  assign bypass = q_empty && !wb_live && bus.mc_valid && mc_ready_q && (bus.mc_rw != 5'd0);
`else
  assign bypass = 1'b0;
`endif

  // Pick the owner of the write port: a forced head drain, then WB, then the queue head, then bypass.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    grant = GNT_NONE;
    if (!rst)          grant = GNT_NONE;
    else if (stall)    grant = GNT_HEAD;
    else if (wb_live)  grant = GNT_WB;
    else if (!q_empty) grant = GNT_HEAD;
    else if (bypass)   grant = GNT_BYP;
  end

  // Drive the register-file write port from the grantee. A squashed head drains without a write.
  always_comb begin
    wr_we = 1'b0;
    wr_rw = 5'd0;
    wr_di = 32'd0;
    unique case (grant)
      GNT_WB:   begin wr_we = 1'b1;              wr_rw = wb_eff_rw;        wr_di = bus.wb_di;        end
      GNT_HEAD: begin wr_we = q_vld_q[rd_ptr_q]; wr_rw = q_rw_q[rd_ptr_q]; wr_di = q_di_q[rd_ptr_q]; end
      GNT_BYP:  begin wr_we = 1'b1;              wr_rw = bus.mc_rw;        wr_di = bus.mc_di;        end
      default:  ;
    endcase
  end

  // Raise a RAW hazard when a decode source matches any still-valid queued destination.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld_q[i] &&
          (((bus.id_ra != 5'd0) && (bus.id_ra == q_rw_q[i])) ||
           ((bus.id_rb != 5'd0) && (bus.id_rb == q_rw_q[i]))))
        hazard = 1'b1;
    end
  end

  assign deq = (grant == GNT_HEAD);
  assign enq = bus.mc_valid && mc_ready_q && (bus.mc_rw != 5'd0) && (grant != GNT_BYP);

  // Next-state logic: entry valid bits (WAW squash, dequeue, enqueue), occupancy and starvation count.
  always_comb begin
    q_vld_d = q_vld_q;
    if (grant == GNT_WB) begin
      for (int i = 0; i < DEPTH; i++)
        if (q_rw_q[i] == wb_eff_rw) q_vld_d[i] = 1'b0;
    end
    if (deq) q_vld_d[rd_ptr_q] = 1'b0;
    if (enq) q_vld_d[wr_ptr_q] = 1'b1;

    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (deq || q_empty)       starve_d = '0;
    else if (grant == GNT_WB) starve_d = starve_q + STV_W'(1);
    else                      starve_d = starve_q;
  end

  // Control state: pointers, occupancy, valid bits, starvation counter and the registered ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      q_vld_q    <= '0;
      mc_ready_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      starve_q   <= starve_d;
      q_vld_q    <= q_vld_d;
      mc_ready_q <= (count_d < CNT_W'(DEPTH));
    end
  end

  // Queue payload storage, written only on enqueue.
  // NOTE: the payload array has no reset. q_vld_q and count_q decide whether a slot is ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      q_rw_q[wr_ptr_q] <= bus.mc_rw;
      q_di_q[wr_ptr_q] <= bus.mc_di;
    end
  end

  assign bus.mc_ready  = mc_ready_q;
  assign bus.id_hazard = hazard;
  assign bus.wb_stall  = stall;
  assign bus.Wr_RegWr  = wr_we;
  assign bus.Wr_Rw     = wr_rw;
  assign bus.Wr_RegDi  = wr_di;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter. The reference model keeps the MC queue as a
// queue of {dest, data, valid} records and applies the arbitration rules directly.
// Directed scenarios run first, then a randomized stretch with occasional resets.
module tb_rf_write_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef enum int {G_NONE, G_WB, G_HEAD, G_BYP} gnt_t;
  typedef struct {
    logic [4:0]  rw;
    logic [31:0] di;
    bit          vld;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  rf_write_arbiter_if bus();

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  ent_t        mq[$];
  int          starve_m = 0;
  bit          rdy_m = 1'b0;
  gnt_t        gnt_m = G_NONE;
  logic [4:0]  eff_m;
  logic        exp_we, exp_rdy, exp_stall, exp_haz;
  logic [4:0]  exp_rw;
  logic [31:0] exp_di;

  // Register file as seen through the DUT write port.
  logic [31:0] rf_dut [32];
  int          wr7 = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic model_eval();
    logic live, empty, stall, byp;
    eff_m = (bus.wb_memtoreg == 2'b10) ? 5'd31 : bus.wb_rw;
    live  = bus.wb_we && (eff_m != 5'd0);
    empty = (mq.size() == 0);
    stall = !empty && (starve_m == LIMIT);
    byp   = 1'b0;
`ifdef RF_BYPASS_EN
    byp = empty && !live && bus.mc_valid && rdy_m && (bus.mc_rw != 5'd0);
`endif
    exp_we = 1'b0; exp_rw = 5'd0; exp_di = 32'd0; exp_haz = 1'b0;
    exp_rdy = 1'b0; exp_stall = 1'b0; gnt_m = G_NONE;
    if (rst) begin
      exp_rdy   = rdy_m;
      exp_stall = stall;
      if (stall || (!live && !empty)) begin
        gnt_m = G_HEAD; exp_we = mq[0].vld; exp_rw = mq[0].rw; exp_di = mq[0].di;
      end else if (live) begin
        gnt_m = G_WB; exp_we = 1'b1; exp_rw = eff_m; exp_di = bus.wb_di;
      end else if (byp) begin
        gnt_m = G_BYP; exp_we = 1'b1; exp_rw = bus.mc_rw; exp_di = bus.mc_di;
      end
      foreach (mq[i])
        if (mq[i].vld && (((bus.id_ra != 0) && (bus.id_ra == mq[i].rw)) ||
                          ((bus.id_rb != 0) && (bus.id_rb == mq[i].rw))))
          exp_haz = 1'b1;
    end
  endtask

  // Model state change at the clock edge.
  task automatic model_update();
    bit was_empty;
    ent_t e;
    if (!rst) begin
      mq.delete(); starve_m = 0; rdy_m = 1'b0;
      return;
    end
    was_empty = (mq.size() == 0);
    if (gnt_m == G_WB)
      foreach (mq[i]) if (mq[i].rw == eff_m) mq[i].vld = 1'b0;
    if (gnt_m == G_HEAD) begin
      void'(mq.pop_front());
      starve_m = 0;
    end else if (was_empty) starve_m = 0;
    else if (gnt_m == G_WB)  starve_m++;
    if (bus.mc_valid && rdy_m && (bus.mc_rw != 5'd0) && (gnt_m != G_BYP)) begin
      e.rw = bus.mc_rw; e.di = bus.mc_di; e.vld = 1'b1;
      mq.push_back(e);
    end
    rdy_m = (mq.size() < DEPTH);
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    check("wr_en",  32'(bus.Wr_RegWr),  32'(exp_we));
    check("wr_rw",  32'(bus.Wr_Rw),     32'(exp_rw));
    check("wr_di",  bus.Wr_RegDi,       exp_di);
    check("ready",  32'(bus.mc_ready),  32'(exp_rdy));
    check("stall",  32'(bus.wb_stall),  32'(exp_stall));
    check("hazard", 32'(bus.id_hazard), 32'(exp_haz));
    if (bus.Wr_RegWr) begin
      rf_dut[bus.Wr_Rw] = bus.Wr_RegDi;
      if (bus.Wr_Rw == 5'd7) wr7++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rw, input logic [31:0] di, input logic [1:0] m2r);
    bus.wb_we = we; bus.wb_rw = rw; bus.wb_di = di; bus.wb_memtoreg = m2r;
  endtask

  task automatic set_mc(input logic v, input logic [4:0] rw, input logic [31:0] di);
    bus.mc_valid = v; bus.mc_rw = rw; bus.mc_di = di;
  endtask

  task automatic set_id(input logic [4:0] ra, input logic [4:0] rb);
    bus.id_ra = ra; bus.id_rb = rb;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    foreach (rf_dut[i]) rf_dut[i] = 32'd0;
    set_wb(0, 0, 0, 0); set_mc(0, 0, 0); set_id(0, 0);

    // Reset, then release. mc_ready rises one edge after the release.
    tick();
    sample(); check("rst_ready", 32'(bus.mc_ready), 32'd0); advance();
    rst = 1'b1;
    tick();

    // JAL forces the destination to $31. A non-JAL write to $0 is dropped.
    set_wb(1, 5, 32'h1234, 2'b10);
    sample();
    check("jal_we", 32'(bus.Wr_RegWr), 32'd1);
    check("jal_rw", 32'(bus.Wr_Rw), 32'd31);
    check("jal_di", bus.Wr_RegDi, 32'h1234);
    advance();
    set_wb(1, 0, 32'hdead, 2'b00);
    sample(); check("zero_we", 32'(bus.Wr_RegWr), 32'd0); advance();

    // Fill the queue while WB is busy, then let it drain.
    set_wb(1, 1, 32'h11, 0); set_mc(1, 8, 32'hA);
    tick();
    set_mc(1, 9, 32'hB);
    sample(); check("fill_rdy1", 32'(bus.mc_ready), 32'd1); advance();
    set_mc(0, 0, 0); set_id(9, 0);
    sample();
    check("fill_full", 32'(bus.mc_ready), 32'd0);
    check("fill_haz", 32'(bus.id_hazard), 32'd1);
    advance();
    set_wb(0, 0, 0, 0); set_id(0, 0);
    sample();
    check("drain1_rw", 32'(bus.Wr_Rw), 32'd8);
    check("drain1_di", bus.Wr_RegDi, 32'hA);
    advance();
    sample();
    check("drain2_rw", 32'(bus.Wr_Rw), 32'd9);
    check("drain2_di", bus.Wr_RegDi, 32'hB);
    check("drain2_rdy", 32'(bus.mc_ready), 32'd1);
    advance();
    tick();

    // Starvation: WB requests every cycle, and the queued r4 is forced out after LIMIT denials.
    set_wb(1, 2, 32'h22, 0); set_mc(1, 4, 32'h55);
    tick();
    set_mc(0, 0, 0);
    for (int i = 0; i < LIMIT; i++) begin
      sample(); check("starve_pre", 32'(bus.wb_stall), 32'd0); advance();
    end
    sample();
    check("starve_stall", 32'(bus.wb_stall), 32'd1);
    check("starve_rw", 32'(bus.Wr_Rw), 32'd4);
    check("starve_di", bus.Wr_RegDi, 32'h55);
    advance();
    sample();
    check("starve_after", 32'(bus.wb_stall), 32'd0);
    check("starve_wb", 32'(bus.Wr_Rw), 32'd2);
    advance();
    set_wb(0, 0, 0, 0);
    tick();

    // WAW squash: a WB write to r7 invalidates the queued r7.
    wr7 = 0;
    set_wb(1, 1, 32'h11, 0); set_mc(1, 7, 32'h1);
    tick();
    set_mc(0, 0, 0); set_wb(1, 7, 32'h2, 0);
    tick();
    set_wb(0, 0, 0, 0); set_id(7, 0);
    sample();
    check("waw_drop", 32'(bus.Wr_RegWr), 32'd0);
    check("waw_haz", 32'(bus.id_hazard), 32'd0);
    advance();
    set_id(0, 0);
    tick(); tick();
    check("waw_r7", rf_dut[7], 32'h2);
    check("waw_cnt", 32'(wr7), 32'd1);

    // MC result while the queue is empty and WB is idle.
    set_mc(1, 3, 32'h77);
    sample();
`ifdef RF_BYPASS_EN
    check("byp_same_we", 32'(bus.Wr_RegWr), 32'd1);
    check("byp_same_rw", 32'(bus.Wr_Rw), 32'd3);
`else
    check("byp_same_we", 32'(bus.Wr_RegWr), 32'd0);
`endif
    advance();
    set_mc(0, 0, 0);
    sample();
`ifdef RF_BYPASS_EN
    check("byp_next_we", 32'(bus.Wr_RegWr), 32'd0);
`else
    check("byp_next_we", 32'(bus.Wr_RegWr), 32'd1);
    check("byp_next_rw", 32'(bus.Wr_Rw), 32'd3);
    check("byp_next_di", bus.Wr_RegDi, 32'h77);
`endif
    advance();

    // Reset with two entries queued while WB is still requesting.
    set_wb(1, 1, 32'h11, 0); set_mc(1, 10, 32'hA0);
    tick();
    set_mc(1, 11, 32'hB0);
    tick();
    set_mc(0, 0, 0);
    rst = 1'b0;
    sample();
    check("rmid_we", 32'(bus.Wr_RegWr), 32'd0);
    check("rmid_rdy", 32'(bus.mc_ready), 32'd0);
    advance();
    rst = 1'b1; set_wb(0, 0, 0, 0);
    tick();
    sample();
    check("rrel_rdy", 32'(bus.mc_ready), 32'd1);
    check("rrel_we", 32'(bus.Wr_RegWr), 32'd0);
    advance();
    tick();

    // Randomized traffic. WB holds its request while a stall is due.
    for (int c = 0; c < 1500; c++) begin
      if (!(mq.size() > 0 && starve_m == LIMIT))
        set_wb(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               2'($urandom_range(0, 3)));
      set_mc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
